// File: rtl/viper_pkg.sv
// viper_pkg: shared widths, address limit and FSM state encoding for the
// VIPER memory interface. The address limit is also used by the processor
// P-bound check, so both sides agree on the legal word-address window.
package viper_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;

  localparam logic [31:0] ADDR_LIMIT = 32'h000F_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  // A CPU word address is reachable only if it fits in the MAR.
  function automatic logic addr_ok(input logic [31:0] addr);
    return addr <= ADDR_LIMIT;
  endfunction

endpackage

// File: rtl/viper_mem_wdog.sv
// viper_mem_wdog: ack watchdog for a single memory transfer.
//   clock, reset_n : clock and async active-low reset
//   clear          : restart the count at zero (transfer accepted)
//   enable         : count one strobe cycle that had no ack
//   expired        : count has reached TIMEOUT-1
module viper_mem_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/viper_mem_if.sv
// viper_mem_if: single-transfer bridge between the VIPER processor and
// word-addressed memory, with an ack watchdog and a sticky fault stop.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : request from processor (IDLE only)
//   cpu_rdata/cpu_done/cpu_busy/cpu_stop : result and status to processor
//   mem_addr/mem_wdata/mem_rd/mem_wr   : MAR, MBR and strobes to memory
//   mem_rdata/mem_ack                  : response from memory
//
// state | meaning
// IDLE  | waiting for cpu_req
// READ  | mem_rd asserted, waiting for mem_ack
// WRITE | mem_wr asserted, waiting for mem_ack
// DONE  | one-cycle completion pulse, MBR on cpu_rdata
// FAULT | bad address or ack timeout; held until reset
module viper_mem_if
  import viper_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic              cpu_stop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t state_q, state_nxt;

  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;

  logic mar_load, mbr_load_w, mbr_load_r;
  logic wd_clear, wd_en, wd_expired;

  viper_mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    mar_load   = 1'b0;
    mbr_load_w = 1'b0;
    mbr_load_r = 1'b0;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (addr_ok(cpu_addr)) begin
            mar_load = 1'b1;
            wd_clear = 1'b1;
            if (cpu_we) begin
              mbr_load_w = 1'b1;
              state_nxt  = WRITE;
            end else begin
              state_nxt = READ;
            end
          end else begin
            state_nxt = FAULT;
          end
        end
      end
      READ: begin
        // An ack in the final allowed cycle still completes the transfer.
        if (mem_ack) begin
          mbr_load_r = 1'b1;
          state_nxt  = DONE;
        end else if (wd_expired) begin
          state_nxt = FAULT;
        end else begin
          wd_en = 1'b1;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_nxt = DONE;
        end else if (wd_expired) begin
          state_nxt = FAULT;
        end else begin
          wd_en = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = FAULT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mar <= '0;
      mbr <= '0;
    end else begin
      if (mar_load) begin
        mar <= cpu_addr[ADDR_W-1:0];
      end
      if (mbr_load_w) begin
        mbr <= cpu_wdata;
      end else if (mbr_load_r) begin
        mbr <= mem_rdata;
      end
    end
  end

  // Status and strobes are flops fed from the next state, so they line up
  // with the state register and carry no path from inputs to outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_done <= 1'b0;
      cpu_busy <= 1'b0;
      cpu_stop <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
    end else begin
      cpu_done <= (state_nxt == DONE);
      cpu_busy <= (state_nxt != IDLE);
      cpu_stop <= (state_nxt == FAULT);
      mem_rd   <= (state_nxt == READ);
      mem_wr   <= (state_nxt == WRITE);
    end
  end

  assign mem_addr  = mar;
  assign mem_wdata = mbr;
  assign cpu_rdata = mbr;

endmodule

// File: tb/tb_viper_mem_if.sv
module tb_viper_mem_if;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] cpu_rdata;
  logic [31:0] mem_wdata;
  logic [19:0] mem_addr;
  logic        cpu_done, cpu_busy, cpu_stop, mem_rd, mem_wr;

  int checks = 0;
  int failures = 0;
  int strobes = 0;
  int s0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  viper_mem_if #(.TIMEOUT(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_busy  (cpu_busy),
    .cpu_stop  (cpu_stop),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Scoreboard: every completion must match the oldest expected result.
  always @(negedge clock) begin
    if (mem_rd || mem_wr) strobes++;
    if (cpu_done) begin
      if (exp_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else chk("sb_rdata", cpu_rdata, exp_q.pop_front());
    end
  end

  initial begin
    #2;
    chk("rst_ctrl", {27'd0, cpu_busy, cpu_done, cpu_stop, mem_rd, mem_wr}, 32'd0);
    chk("rst_addr", {12'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Read, ack on 3rd strobe cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1234;
    mem_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    cpu_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("rd_strobe", {31'd0, mem_rd}, 32'd1);
      chk("rd_addr", {12'd0, mem_addr}, 32'h0001_234);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("rd_done", {31'd0, cpu_done}, 32'd1);
    chk("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_strobe_off", {31'd0, mem_rd}, 32'd0);
    tick();
    chk("rd_done_pulse", {31'd0, cpu_done}, 32'd0);
    chk("rd_idle", {31'd0, cpu_busy}, 32'd0);
    chk("rd_hold", cpu_rdata, 32'hDEAD_BEEF);

    // Write to top address, immediate ack
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h000F_FFFF; cpu_wdata = 32'hA5A5_5A5A;
    exp_q.push_back(32'hA5A5_5A5A);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("wr_strobe", {30'd0, mem_wr, mem_rd}, 32'd2);
    chk("wr_wdata", mem_wdata, 32'hA5A5_5A5A);
    chk("wr_addr", {12'd0, mem_addr}, 32'h000F_FFFF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wr_done_lat", {31'd0, cpu_done}, 32'd1);
    chk("wr_strobe_off", {31'd0, mem_wr}, 32'd0);
    chk("wr_rdata", cpu_rdata, 32'hA5A5_5A5A);
    tick();

    // Ack in the last allowed cycle (TIMEOUT=4) wins
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0055;
    mem_rdata = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    tick();
    cpu_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("edge_strobe", {31'd0, mem_rd}, 32'd1);
      if (i == 4) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("edge_done", {31'd0, cpu_done}, 32'd1);
    chk("edge_nostop", {31'd0, cpu_stop}, 32'd0);
    tick();

    // Back-to-back with cpu_req and mem_ack held high
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100;
    mem_rdata = 32'h1111_1111; mem_ack = 1'b1;
    exp_q.push_back(32'h1111_1111);
    exp_q.push_back(32'h2222_2222);
    tick();
    chk("b2b_rd1", {31'd0, mem_rd}, 32'd1);
    tick();
    chk("b2b_done1", {31'd0, cpu_done}, 32'd1);
    mem_rdata = 32'h2222_2222;
    tick();
    chk("b2b_idle", {30'd0, cpu_busy, cpu_done}, 32'd0);
    tick();
    chk("b2b_rd2", {31'd0, mem_rd}, 32'd1);
    cpu_req = 1'b0;
    tick();
    chk("b2b_done2", {31'd0, cpu_done}, 32'd1);
    tick();
    chk("b2b_idle2", {31'd0, cpu_busy}, 32'd0);
    tick();
    chk("stray_ack", {30'd0, cpu_busy, mem_rd}, 32'd0);
    mem_ack = 1'b0;

    // Reset in the middle of a read, ack arriving afterwards
    cpu_req = 1'b1; cpu_addr = 32'h0000_0200; mem_rdata = 32'h0BAD_F00D;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("mid_rd", {31'd0, mem_rd}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async", {30'd0, mem_rd, cpu_busy}, 32'd0);
    mem_ack = 1'b1;
    repeat (2) tick();
    chk("rst2_ctrl", {27'd0, cpu_busy, cpu_done, cpu_stop, mem_rd, mem_wr}, 32'd0);
    chk("rst2_addr", {12'd0, mem_addr}, 32'd0);
    chk("rst2_rdata", cpu_rdata, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cpu_req = 1'b1; cpu_addr = 32'h0000_0300; mem_rdata = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    tick();
    chk("post_rst_accept", {31'd0, mem_rd}, 32'd1);
    cpu_req = 1'b0;
    tick();
    chk("post_rst_done", {31'd0, cpu_done}, 32'd1);
    chk("post_rst_rdata", cpu_rdata, 32'hCAFE_F00D);
    mem_ack = 1'b0;
    tick();

    // Timeout: no ack for 4 strobe cycles
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
    tick();
    cpu_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("to_strobe", {30'd0, mem_rd, cpu_stop}, 32'd2);
      tick();
    end
    chk("to_fault", {29'd0, cpu_stop, cpu_busy, mem_rd}, 32'd6);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0010; mem_ack = 1'b1;
    repeat (3) tick();
    chk("fault_absorb", {28'd0, cpu_stop, mem_rd, mem_wr, cpu_done}, 32'd8);
    cpu_req = 1'b0; cpu_we = 1'b0; mem_ack = 1'b0;

    // Out-of-range address goes straight to FAULT
    do_reset();
    chk("rst_stop_clear", {31'd0, cpu_stop}, 32'd0);
    s0 = strobes;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0010_0000;
    tick();
    cpu_req = 1'b0;
    chk("bad_fault", {30'd0, cpu_stop, cpu_busy}, 32'd3);
    cpu_req = 1'b1; cpu_addr = 32'h0000_0020; mem_ack = 1'b1;
    repeat (3) tick();
    cpu_req = 1'b0; mem_ack = 1'b0;
    chk("bad_sticky", {31'd0, cpu_stop}, 32'd1);
    chk("bad_no_strobe", strobes - s0, 32'd0);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/viper_mem_if.md
VIPER_MEM_IF -- requirements
Module: viper_mem_if

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum number of cycles to wait for mem_ack before a fault is raised; the legal range is 2..255.
REQ-002 clock  input  1  is the single rising-edge clock.
REQ-003 reset_n  input  1  is an asynchronous, active-low reset.
REQ-004 cpu_req  input  1  requests a memory transfer; it is sampled only in IDLE.
REQ-005 cpu_we  input  1  selects the direction: 1 for write, 0 for read.
REQ-006 cpu_addr  input  32  is the word address from the processor.
REQ-007 cpu_wdata  input  32  is the write data.
REQ-008 cpu_rdata  output  32  is the MBR contents, valid when cpu_done is high.
REQ-009 cpu_done  output  1  is a one-cycle completion pulse.
REQ-010 cpu_busy  output  1  is high in every state except IDLE.
REQ-011 cpu_stop  output  1  is a sticky fault flag that feeds the processor STOP.
REQ-012 mem_addr  output  20  is the MAR.
REQ-013 mem_wdata  output  32  is the MBR on writes.
REQ-014 mem_rd  output  1  is the read strobe.
REQ-015 mem_wr  output  1  is the write strobe.
REQ-016 mem_rdata  input  32  is the memory read data.
REQ-017 mem_ack  input  1  is the memory completion signal.

Function
REQ-018 The FSM SHALL have the states IDLE, READ, WRITE, DONE and FAULT.
REQ-019 In IDLE with cpu_req=1 and cpu_addr[31:20]=0, the block SHALL latch MAR=cpu_addr[19:0] and latch MBR=cpu_wdata if cpu_we=1, clear the timeout counter, and go to WRITE if cpu_we=1 or READ if cpu_we=0.
REQ-020 In IDLE with cpu_req=1 and cpu_addr[31:20]!=0, the block SHALL go to FAULT without asserting any memory strobe.
REQ-021 mem_rd SHALL be high exactly while in READ, and mem_wr SHALL be high exactly while in WRITE.
REQ-022 mem_addr and mem_wdata SHALL stay stable throughout READ and WRITE.
REQ-023 In READ, mem_ack=1 SHALL load MBR from mem_rdata and move to DONE.
REQ-024 In WRITE, mem_ack=1 SHALL move to DONE.
REQ-025 In DONE, cpu_done SHALL be 1 and cpu_rdata SHALL equal MBR for one cycle, and the next state SHALL be IDLE unconditionally.
REQ-026 Minimum latency: with mem_ack on the first strobe cycle, cpu_done SHALL assert 2 cycles after the cycle in which cpu_req was accepted.
REQ-027 The timeout counter SHALL increment on each READ or WRITE cycle without an ack; when it reaches TIMEOUT-1 without an ack, the next state SHALL be FAULT.
REQ-028 If mem_ack arrives in the same cycle the counter reaches TIMEOUT-1, the ack SHALL win and the next state SHALL be DONE.
REQ-029 FAULT SHALL be absorbing: cpu_stop=1, cpu_busy=1, both strobes low, and no exit except reset.
REQ-030 cpu_req SHALL be ignored in every state other than IDLE, including the DONE cycle, so a back-to-back request is accepted one cycle after DONE.
REQ-031 mem_ack SHALL be ignored in IDLE, DONE and FAULT.
REQ-032 cpu_rdata SHALL hold the last MBR value outside DONE, and on a write it SHALL show the write data.
REQ-033 All outputs SHALL be registered and SHALL have no combinational path from any input.

Reset
REQ-034 reset_n=0 SHALL immediately force IDLE, with MAR=0, MBR=0, counter=0 and every output 0.
REQ-035 A reset asserted during READ or WRITE SHALL drop the strobes asynchronously, and the aborted transfer SHALL never report completion.
REQ-036 After release, the first rising edge SHALL be able to accept cpu_req.

Structure
REQ-037 The package viper_pkg SHALL hold ADDR_W=20, DATA_W=32, the FSM state enum, and the constant ADDR_LIMIT=32'h000F_FFFF that is shared with the processor P-bound check.
REQ-038 A single sub-module, viper_mem_wdog, is natural: it is the TIMEOUT-parameterised counter with clear, enable and expired outputs.
REQ-039 MAR and MBR SHALL be the only datapath registers.

Verification
REQ-040 Read, address 32'h0000_1234, mem_rdata 32'hDEAD_BEEF, ack on the 3rd strobe cycle -> mem_rd high for 3 cycles with mem_addr=20'h01234, then cpu_done for one cycle with cpu_rdata=32'hDEAD_BEEF.
REQ-041 Write, address 32'h000F_FFFF, data 32'hA5A5_5A5A, immediate ack -> mem_wr high for 1 cycle, mem_wdata=32'hA5A5_5A5A, cpu_done 2 cycles after accept.
REQ-042 Request with address 32'h0010_0000 -> FAULT, cpu_stop=1, mem_rd and mem_wr never asserted, and a later cpu_req is ignored.
REQ-043 TIMEOUT=4 and no ack -> FAULT after 4 strobe cycles; a second run with ack in the 4th cycle -> DONE with no fault.
REQ-044 Reset pulsed mid-READ with ack arriving afterwards -> no cpu_done, IDLE, all outputs 0, and the next request completes normally.
REQ-045 Back-to-back requests with cpu_req held high -> the second transfer starts the cycle after DONE, and stray mem_ack pulses in IDLE cause no state change.
